// File: rtl/gt_pll_ctrl_pkg.sv
// Shared types and default timing for the GTP common PLL supervisor.
// Optional loss counters are enabled by GT_PLL_LOSS_CNT_EN.
package gt_pll_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POWERUP,
    WAIT_REF,
    WAIT_LOCK,
    LOCKED,
    FAILED
  } pll_state_t;

  localparam int unsigned RST_CYCLES_DEF    = 32;
  localparam int unsigned LOCK_TIMEOUT_DEF  = 65536;
  localparam int unsigned STABLE_CYCLES_DEF = 256;
  localparam int unsigned MAX_RETRY_DEF     = 4;
  localparam int unsigned LOSS_W            = 8;

endpackage

// File: rtl/gt_pll_rst_fsm.sv
// One PLL channel: input syncs, power/reset FSM, timeout and retry.
// GT_PLL_LOSS_CNT_EN adds a saturating lock-loss counter.
module gt_pll_rst_fsm
  import gt_pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = RST_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned MAX_RETRY     = MAX_RETRY_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic lock,
  input  logic lost,
  output logic pd,
  output logic reset,
  output logic ready,
  output logic fail
`ifdef GT_PLL_LOSS_CNT_EN
  ,
  output logic [LOSS_W-1:0] loss_cnt
`endif
);

  localparam int CW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  pll_state_t    state, nxt;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmo;
  logic [SW-1:0] stab;
  logic [RW-1:0] retry;
  logic          lock_m, lock_s;
  logic          lost_m, lost_s;
  logic          stab_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
      lost_m <= 1'b0;
      lost_s <= 1'b0;
    end else begin
      lock_m <= lock;
      lock_s <= lock_m;
      lost_m <= lost;
      lost_s <= lost_m;
    end
  end

  assign stab_hit = lock_s && (stab == SW'(STABLE_CYCLES - 1));

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:      if (en) nxt = POWERUP;
      POWERUP:   if (cnt == '0) nxt = lost_s ? WAIT_REF : WAIT_LOCK;
      WAIT_REF:  if (!lost_s) nxt = POWERUP;
      WAIT_LOCK: begin
        if (lost_s)         nxt = WAIT_REF;
        else if (stab_hit)  nxt = LOCKED;
        else if (tmo == '0)
          nxt = (retry < RW'(MAX_RETRY)) ? POWERUP : FAILED;
      end
      LOCKED: begin
        if (lost_s)       nxt = WAIT_REF;
        else if (!lock_s) nxt = POWERUP;
      end
      FAILED:    nxt = FAILED;
      default:   nxt = IDLE;
    endcase
    if (!en) nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      tmo   <= '0;
      stab  <= '0;
      retry <= '0;
    end else begin
      state <= nxt;
      // every entry into POWERUP restarts the reset hold
      if (nxt == POWERUP && state != POWERUP)
        cnt <= CW'(RST_CYCLES - 1);
      else if (state == POWERUP && cnt != '0)
        cnt <= cnt - 1'b1;
      if (nxt == WAIT_LOCK && state != WAIT_LOCK) begin
        tmo  <= TW'(LOCK_TIMEOUT - 1);
        stab <= '0;
      end else if (state == WAIT_LOCK) begin
        if (tmo != '0) tmo <= tmo - 1'b1;
        stab <= lock_s ? stab + 1'b1 : '0;
      end
      if (nxt == IDLE || nxt == LOCKED)
        retry <= '0;
      else if (state == WAIT_LOCK && nxt == POWERUP)
        retry <= retry + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pd    <= 1'b1;
      reset <= 1'b1;
      ready <= 1'b0;
      fail  <= 1'b0;
    end else begin
      pd    <= (state == IDLE) || (state == FAILED);
      reset <= !((state == WAIT_LOCK) || (state == LOCKED));
      ready <= (state == LOCKED);
      fail  <= (state == FAILED);
    end
  end

`ifdef GT_PLL_LOSS_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      loss_cnt <= '0;
    else if (state == LOCKED && (nxt == POWERUP || nxt == WAIT_REF)
             && loss_cnt != '1)
      loss_cnt <= loss_cnt + 1'b1;
  end
`endif

endmodule

// File: rtl/gt_pll_reset_ctrl.sv
// PLL0 (PCIe) / PLL1 (SFP) power, reset and lock supervisor.
// GT_PLL_LOSS_CNT_EN adds PLL0LOSSCNT / PLL1LOSSCNT outputs.
module gt_pll_reset_ctrl
  import gt_pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = RST_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned MAX_RETRY     = MAX_RETRY_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic PLL0_EN,
  input  logic PLL1_EN,
  input  logic PLL0LOCK,
  input  logic PLL1LOCK,
  input  logic PLL0REFCLKLOST,
  input  logic PLL1REFCLKLOST,
  output logic PLL0PD,
  output logic PLL1PD,
  output logic PLL0RESET,
  output logic PLL1RESET,
  output logic PLL0READY,
  output logic PLL1READY,
  output logic PLL0FAIL,
  output logic PLL1FAIL
`ifdef GT_PLL_LOSS_CNT_EN
  ,
  output logic [LOSS_W-1:0] PLL0LOSSCNT,
  output logic [LOSS_W-1:0] PLL1LOSSCNT
`endif
);

  gt_pll_rst_fsm #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRY    (MAX_RETRY)
  ) u_pll0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (PLL0_EN),
    .lock    (PLL0LOCK),
    .lost    (PLL0REFCLKLOST),
    .pd      (PLL0PD),
    .reset   (PLL0RESET),
    .ready   (PLL0READY),
    .fail    (PLL0FAIL)
`ifdef GT_PLL_LOSS_CNT_EN
    ,
    .loss_cnt(PLL0LOSSCNT)
`endif
  );

  gt_pll_rst_fsm #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRY    (MAX_RETRY)
  ) u_pll1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (PLL1_EN),
    .lock    (PLL1LOCK),
    .lost    (PLL1REFCLKLOST),
    .pd      (PLL1PD),
    .reset   (PLL1RESET),
    .ready   (PLL1READY),
    .fail    (PLL1FAIL)
`ifdef GT_PLL_LOSS_CNT_EN
    ,
    .loss_cnt(PLL1LOSSCNT)
`endif
  );

endmodule

// File: doc/gt_pll_reset_ctrl.md
Name: gt_pll_reset_ctrl

Overview:
- Power-up, reset and lock supervisor for the two PLLs of the GTP common quad (PLL0 = PCIe, PLL1 = SFP).
- Drives PLLxPD and PLLxRESET, qualifies PLLxLOCK and PLLxREFCLKLOST, retries on lock timeout, and reports per-PLL READY/FAIL.
- Sits between system control logic and the gt_common_wrapper instance.
- The two PLL channels are fully independent.

Parameters:
- RST_CYCLES, 32: cycles PLLxRESET is held after PD release.
- LOCK_TIMEOUT, 65536: cycles allowed from reset release to qualified lock.
- STABLE_CYCLES, 256: consecutive synced-lock-high cycles required to declare READY.
- MAX_RETRY, 4: lock-timeout retries before FAIL.
- All counter widths are $clog2(max value + 1).

Ports:
- clk  in  1  free-running control clock; also drives PLLxLOCKDETCLK externally.
- rst_n  in  1  asynchronous, active-low reset.
- PLL0_EN  in  1  clk-domain request to run PLL0; low powers it down.
- PLL1_EN  in  1  as above, for PLL1.
- PLL0LOCK, PLL1LOCK  in  1 each  raw lock from GTPE2_COMMON (async).
- PLL0REFCLKLOST, PLL1REFCLKLOST  in  1 each  raw refclk-lost (async).
- PLL0PD, PLL1PD  out  1 each  PLL power-down.
- PLL0RESET, PLL1RESET  out  1 each  PLL reset.
- PLL0READY, PLL1READY  out  1 each  qualified lock.
- PLL0FAIL, PLL1FAIL  out  1 each  retries exhausted.

Behaviour:
- Clocking and reset: single clk domain. rst_n is asynchronous assert, active-low; deassertion is synchronised by the integrator.
- Input synchronisation: LOCK and REFCLKLOST pass through 2-flop synchronisers (lock_s, lost_s) with 2-cycle latency.
- Outputs are registered and decoded from state (Moore), so each output changes one cycle after the state change.
- Reset values:
  - PD = 1, RESET = 1, READY = 0, FAIL = 0.
  - State IDLE; retry counter 0; synchroniser flops 0.
- Per-channel FSM:
  - IDLE (PD = 1, RESET = 1): EN = 1 -> POWERUP; load cnt = RST_CYCLES - 1.
  - POWERUP (PD = 0, RESET = 1): decrement cnt.
    - cnt == 0 and lost_s = 0 -> WAIT_LOCK; load tmo = LOCK_TIMEOUT - 1; clear stab.
    - cnt == 0 and lost_s = 1 -> WAIT_REF.
  - WAIT_REF (PD = 0, RESET = 1): lost_s = 0 -> POWERUP (cnt reloaded).
  - WAIT_LOCK (PD = 0, RESET = 0):
    - stab counts consecutive lock_s = 1 cycles and clears on lock_s = 0.
    - stab == STABLE_CYCLES - 1 with lock_s = 1 -> LOCKED.
    - Else tmo == 0 and retry < MAX_RETRY -> POWERUP, retry++.
    - Else tmo == 0 -> FAILED.
  - LOCKED (PD = 0, RESET = 0, READY = 1): entry clears retry.
    - lock_s = 0 -> POWERUP (relock; retry not incremented).
  - FAILED (PD = 1, RESET = 1, FAIL = 1): sticky.
- Global overrides, in priority order:
  - EN = 0 in any state -> IDLE next cycle; retry cleared. This is the only exit from FAILED.
  - lost_s = 1 in WAIT_LOCK or LOCKED -> WAIT_REF; READY drops the following cycle.
- Simultaneous events in WAIT_LOCK:
  - Qualified lock and timeout in the same cycle: lock wins.
  - lost_s wins over both.
- rst_n mid-operation: all outputs go to reset values immediately (async); PLLs return to PD.
- Channels share no state; both may sequence concurrently.

Optional Feature:
- GT_PLL_LOSS_CNT_EN
- Defined:
  - Adds outputs PLL0LOSSCNT and PLL1LOSSCNT, 8 bits each.
  - Saturating counters incremented on every LOCKED -> POWERUP or LOCKED -> WAIT_REF transition; saturate at 255.
  - Cleared only by rst_n.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package gt_pll_ctrl_pkg:
  - typedef enum logic [2:0] pll_state_t {IDLE, POWERUP, WAIT_REF, WAIT_LOCK, LOCKED, FAILED}.
  - Localparam default timing constants.
- Sub-module gt_pll_rst_fsm: one channel (synchronisers, FSM, counters, optional loss counter).
- Top instantiates it twice and maps ports.

Test Plan:
- Test parameters for all scenarios: RST_CYCLES = 4, LOCK_TIMEOUT = 64, STABLE_CYCLES = 8, MAX_RETRY = 2.
- Nominal bring-up: EN0 rises at cycle 0, PLL0LOCK high from cycle 10.
  - PD0 low at cycle 2.
  - RESET0 low at cycle 6.
  - READY0 high at cycle 21; RESET0 never reasserted.
- Timeout and retry: EN1 = 1, LOCK1 held 0.
  - RESET1 reasserts after each 64-cycle window.
  - After 3 windows (2 retries), FAIL1 = 1 and PD1 = 1.
  - EN1 toggled 0 then 1 -> FAIL1 = 0 and the sequence restarts.
- Lock loss while READY: drop LOCK0 for 1 cycle.
  - READY0 low 3 cycles later; RESET0 pulses for 4 cycles; READY re-acquired.
  - With GT_PLL_LOSS_CNT_EN: PLL0LOSSCNT = 1.
- Refclk lost: REFCLKLOST0 = 1 while LOCKED.
  - READY0 falls; RESET0 = 1 and PD0 = 0 held while lost.
  - On clear: POWERUP, then normal lock.
- Glitch rejection: LOCK0 high 5 cycles, low 1, high again -> READY0 asserts only after 8 consecutive synced-high cycles.
- Async reset mid-WAIT_LOCK: rst_n low -> PD = 1, RESET = 1, READY = 0, FAIL = 0 within the same cycle on both channels.
